// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and constants for the direct-mapped data cache:
//                load/store command encodings, miss FSM states, block geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

    localparam int BLOCK_BITS = 128;
    localparam int OFFSET_W   = 4;
    localparam int ADDR_W     = 32;
    localparam int BLK_ADDR_W = ADDR_W - OFFSET_W;

    // Load funct3 encodings (MEM_READ[2:0])
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store size encodings (MEM_WRITE[1:0])
    localparam logic [1:0] SB = 2'b00;
    localparam logic [1:0] SH = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        FETCH      = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/data_cache_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache_if
//  Description : CPU data port and main-memory block port of the data cache.
//                slave = cache view, master = CPU/memory environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_cache_if;
    import dcache_pkg::*;

    logic [ADDR_W-1:0]     ADDRESS;
    logic [31:0]           WRITE_DATA;
    logic [3:0]            MEM_READ;
    logic [2:0]            MEM_WRITE;
    logic [31:0]           READ_DATA;
    logic                  BUSYWAIT;
    logic [BLK_ADDR_W-1:0] MAIN_MEM_ADDR;
    logic                  MAIN_MEM_READ;
    logic                  MAIN_MEM_WRITE;
    logic [BLOCK_BITS-1:0] MAIN_MEM_WRITEDATA;
    logic [BLOCK_BITS-1:0] MAIN_MEM_READDATA;
    logic                  MAIN_MEM_BUSYWAIT;

    modport slave (
        input  ADDRESS, WRITE_DATA, MEM_READ, MEM_WRITE,
        input  MAIN_MEM_READDATA, MAIN_MEM_BUSYWAIT,
        output READ_DATA, BUSYWAIT,
        output MAIN_MEM_ADDR, MAIN_MEM_READ, MAIN_MEM_WRITE, MAIN_MEM_WRITEDATA
    );

    modport master (
        output ADDRESS, WRITE_DATA, MEM_READ, MEM_WRITE,
        output MAIN_MEM_READDATA, MAIN_MEM_BUSYWAIT,
        input  READ_DATA, BUSYWAIT,
        input  MAIN_MEM_ADDR, MAIN_MEM_READ, MAIN_MEM_WRITE, MAIN_MEM_WRITEDATA
    );

endinterface
`default_nettype wire

// File: rtl/load_store_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_aligner
//  Description : Combinational word select, load extract/extend and store
//                byte-merge for one 128-bit cache block.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_aligner
    import dcache_pkg::*;
(
    input  wire logic [BLOCK_BITS-1:0] i_block,
    input  wire logic [OFFSET_W-1:0]   i_offset,
    input  wire logic [2:0]            i_funct3,
    input  wire logic [1:0]            i_store_size,
    input  wire logic [31:0]           i_store_data,
    output logic      [31:0]           o_load_data,
    output logic      [BLOCK_BITS-1:0] o_merged_block
);

    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_new_word;

    // Pick the addressed word, then the addressed byte/halfword, and extend it
    always_comb begin
        w_word = i_block[{i_offset[3:2], 5'd0} +: 32];
        w_byte = w_word[{i_offset[1:0], 3'd0} +: 8];
        w_half = w_word[{i_offset[1], 4'd0} +: 16];
        case (i_funct3)
            LB:      o_load_data = {{24{w_byte[7]}}, w_byte};
            LBU:     o_load_data = {24'd0, w_byte};
            LH:      o_load_data = {{16{w_half[15]}}, w_half};
            LHU:     o_load_data = {16'd0, w_half};
            default: o_load_data = w_word;
        endcase
    end

    // Merge the store bytes into the addressed word and rebuild the block
    always_comb begin
        w_new_word = w_word;
        case (i_store_size)
            SB:      w_new_word[{i_offset[1:0], 3'd0} +: 8] = i_store_data[7:0];
            SH:      w_new_word[{i_offset[1], 4'd0} +: 16]  = i_store_data[15:0];
            SW:      w_new_word = i_store_data;
            default: w_new_word = w_word;
        endcase
        o_merged_block = i_block;
        o_merged_block[{i_offset[3:2], 5'd0} +: 32] = w_new_word;
    end

endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache
//  Description : Direct-mapped, write-back, write-allocate data cache with a
//                three-state miss FSM (IDLE / WRITE_BACK / FETCH).
//  Revision    : 1.0 - initial release
// ============================================================================
module data_cache
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 8
) (
    input  wire logic   CLK,
    input  wire logic   RST,
    data_cache_if.slave bus
);

    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = BLK_ADDR_W - IW;

    logic [NUM_SETS-1:0]   r_valid;
    logic [NUM_SETS-1:0]   r_dirty;
    logic [TW-1:0]         r_tag  [NUM_SETS];
    logic [BLOCK_BITS-1:0] r_data [NUM_SETS];

    state_t r_state;
    state_t w_next_state;

    logic [IW-1:0]         w_index;
    logic [TW-1:0]         w_tag;
    logic                  w_req;
    logic                  w_store;
    logic                  w_hit;
    logic                  w_install;
    logic                  w_store_hit;
    logic [31:0]           w_load_data;
    logic [BLOCK_BITS-1:0] w_merged_block;

    assign w_index = bus.ADDRESS[OFFSET_W +: IW];
    assign w_tag   = bus.ADDRESS[ADDR_W-1 -: TW];
    assign w_req   = bus.MEM_READ[3] | bus.MEM_WRITE[2];
    assign w_store = bus.MEM_WRITE[2];
    assign w_hit   = r_valid[w_index] && (r_tag[w_index] == w_tag);

    load_store_aligner u_aligner (
        .i_block        (r_data[w_index]),
        .i_offset       (bus.ADDRESS[OFFSET_W-1:0]),
        .i_funct3       (bus.MEM_READ[2:0]),
        .i_store_size   (bus.MEM_WRITE[1:0]),
        .i_store_data   (bus.WRITE_DATA),
        .o_load_data    (w_load_data),
        .o_merged_block (w_merged_block)
    );

    // Next-state and output decode; a combined load+store is handled as a store
    always_comb begin
        w_next_state           = r_state;
        w_install              = 1'b0;
        w_store_hit            = 1'b0;
        bus.BUSYWAIT           = 1'b0;
        bus.READ_DATA          = 32'd0;
        bus.MAIN_MEM_READ      = 1'b0;
        bus.MAIN_MEM_WRITE     = 1'b0;
        bus.MAIN_MEM_ADDR      = '0;
        bus.MAIN_MEM_WRITEDATA = '0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        if (w_store) begin
                            w_store_hit = 1'b1;
                        end else begin
                            bus.READ_DATA = w_load_data;
                        end
                    end else begin
                        bus.BUSYWAIT = 1'b1;
                        w_next_state = (r_valid[w_index] && r_dirty[w_index]) ? WRITE_BACK : FETCH;
                    end
                end
            end
            WRITE_BACK: begin
                bus.BUSYWAIT           = 1'b1;
                bus.MAIN_MEM_WRITE     = 1'b1;
                bus.MAIN_MEM_ADDR      = {r_tag[w_index], w_index};
                bus.MAIN_MEM_WRITEDATA = r_data[w_index];
                if (!bus.MAIN_MEM_BUSYWAIT) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                bus.BUSYWAIT      = 1'b1;
                bus.MAIN_MEM_READ = 1'b1;
                bus.MAIN_MEM_ADDR = bus.ADDRESS[ADDR_W-1:OFFSET_W];
                if (!bus.MAIN_MEM_BUSYWAIT) begin
                    w_install    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Line status: reset drops every line, including dirty ones
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (w_install) begin
            r_valid[w_index] <= 1'b1;
            r_dirty[w_index] <= 1'b0;
        end else if (w_store_hit) begin
            r_dirty[w_index] <= 1'b1;
        end
    end

    // Line storage: block install on fetch completion, byte merge on store hit
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (w_install) begin
                r_tag[w_index]  <= w_tag;
                r_data[w_index] <= bus.MAIN_MEM_READDATA;
            end else if (w_store_hit) begin
                r_data[w_index] <= w_merged_block;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_cache
//  Description : Self-checking bench for data_cache: main-memory model with
//                programmable latency, flat CPU-view memory model, line-state
//                model for hit/miss/dirty prediction, directed + random ops.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;

    localparam int NBLK = 512;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    data_cache_if bus ();

    data_cache #(.NUM_SETS(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int lat    = 5;

    // ---------------- main memory model ----------------
    logic [127:0]    mm_mem [NBLK];
    logic [NBLK-1:0] mm_written = '0;
    int              mm_cnt = 0;

    function automatic logic [127:0] init_block(input int b);
        logic [31:0] x;
        x = 32'(b);
        if (b == 4) return {32'h0BAD_F00D, 32'h1357_9BDF, 32'h8765_4321, 32'h0000_80F0};
        return {x * 32'h9E37_79B9, x ^ 32'hC3C3_1234, x * 32'h0101_0101 + 32'h8000_0080, ~x};
    endfunction

    function automatic logic [127:0] mm_read(input int b);
        return mm_written[b] ? mm_mem[b] : init_block(b);
    endfunction

    assign bus.MAIN_MEM_READDATA = mm_read(int'(bus.MAIN_MEM_ADDR[8:0]));
    assign bus.MAIN_MEM_BUSYWAIT = (mm_cnt != lat - 1);

    // Request completes on the cycle the counter reaches lat-1
    always @(posedge CLK) begin
        if (RST) begin
            mm_cnt <= 0;
        end else if (bus.MAIN_MEM_READ || bus.MAIN_MEM_WRITE) begin
            if (mm_cnt == lat - 1) begin
                mm_cnt <= 0;
                if (bus.MAIN_MEM_WRITE) begin
                    mm_mem[bus.MAIN_MEM_ADDR[8:0]]     <= bus.MAIN_MEM_WRITEDATA;
                    mm_written[bus.MAIN_MEM_ADDR[8:0]] <= 1'b1;
                end
            end else begin
                mm_cnt <= mm_cnt + 1;
            end
        end else begin
            mm_cnt <= 0;
        end
    end

    // ---------------- reference model ----------------
    logic [127:0] golden [NBLK];   // what the CPU must observe at each block
    bit           mv [8];
    bit           md [8];
    int           mblk [8];

    function automatic logic [31:0] exp_load(input logic [127:0] blk, input logic [3:0] off,
                                             input logic [2:0] f3);
        int n, base;
        bit sx;
        logic [31:0] v;
        case (f3)
            3'b000:  begin n = 1; sx = 1'b1; base = int'(off); end
            3'b001:  begin n = 2; sx = 1'b1; base = int'(off) & ~1; end
            3'b100:  begin n = 1; sx = 1'b0; base = int'(off); end
            3'b101:  begin n = 2; sx = 1'b0; base = int'(off) & ~1; end
            default: begin n = 4; sx = 1'b0; base = int'(off) & ~3; end
        endcase
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = blk[8*(base+i) +: 8];
        if (sx && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [127:0] apply_store(input logic [127:0] blk, input logic [3:0] off,
                                                 input logic [1:0] sz, input logic [31:0] d);
        int n, base;
        n    = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        base = int'(off) & ~(n - 1);
        for (int i = 0; i < n; i++) blk[8*(base+i) +: 8] = d[8*i +: 8];
        return blk;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One CPU access, checked every cycle until it is serviced
    task automatic do_access(input logic [31:0] a, input logic [3:0] mr, input logic [2:0] mw,
                             input logic [31:0] wd, output int stall, output logic [31:0] rd);
        int  b, idx, es, fs;
        bit  hit, wb, st, want_wr, want_rd;
        b   = int'(a[12:4]);
        idx = b % 8;
        st  = mw[2];
        hit = mv[idx] && (mblk[idx] == b);
        wb  = !hit && mv[idx] && md[idx];
        es  = hit ? 0 : (wb ? 1 + 2*lat : 1 + lat);
        fs  = wb ? 1 + lat : 1;
        bus.ADDRESS = a; bus.MEM_READ = mr; bus.MEM_WRITE = mw; bus.WRITE_DATA = wd;
        stall = 0;
        rd    = 32'd0;
        for (int k = 0; k <= es; k++) begin
            @(negedge CLK);
            if (bus.BUSYWAIT) stall++;
            want_wr = wb && (k >= 1) && (k <= lat);
            want_rd = !hit && (k >= fs) && (k < fs + lat);
            chk("busywait", bus.BUSYWAIT, k < es);
            chk("mm_write", bus.MAIN_MEM_WRITE, want_wr);
            chk("mm_read", bus.MAIN_MEM_READ, want_rd);
            if (want_wr) begin
                chk("wb_addr", bus.MAIN_MEM_ADDR, 28'(mblk[idx]));
                chk("wb_data", bus.MAIN_MEM_WRITEDATA, golden[mblk[idx]]);
            end
            if (want_rd) chk("fetch_addr", bus.MAIN_MEM_ADDR, 28'(b));
            if (k == es && !st && mr[3]) begin
                rd = bus.READ_DATA;
                chk("read_data", bus.READ_DATA, exp_load(golden[b], a[3:0], mr[2:0]));
            end
            @(posedge CLK);
            #1;
        end
        bus.MEM_READ = 4'd0; bus.MEM_WRITE = 3'd0;
        if (!hit) md[idx] = 1'b0;
        mv[idx]   = 1'b1;
        mblk[idx] = b;
        if (st) begin
            golden[b] = apply_store(golden[b], a[3:0], mw[1:0], wd);
            md[idx]   = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          s;
        logic [31:0] r;
        logic [31:0] a;
        logic [2:0]  f3;
        logic [1:0]  sz;
        int          sel;
        bit          found;

        for (int i = 0; i < NBLK; i++) golden[i] = init_block(i);
        for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; mblk[i] = 0; end
        RST = 1'b1;
        bus.ADDRESS = 32'd0; bus.WRITE_DATA = 32'd0; bus.MEM_READ = 4'd0; bus.MEM_WRITE = 3'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busywait", bus.BUSYWAIT, 1'b0);
        chk("rst_read_data", bus.READ_DATA, 32'd0);
        chk("rst_mm_read", bus.MAIN_MEM_READ, 1'b0);
        chk("rst_mm_write", bus.MAIN_MEM_WRITE, 1'b0);
        chk("rst_mm_addr", bus.MAIN_MEM_ADDR, 28'd0);
        chk("rst_mm_wdata", bus.MAIN_MEM_WRITEDATA, 128'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Clean miss then hits in the same line
        lat = 5;
        do_access(32'h40, 4'b1010, 3'b000, 32'd0, s, r);
        chk("lw40_stall", 32'(s), 32'd6);
        chk("lw40_data", r, 32'h0000_80F0);
        do_access(32'h44, 4'b1010, 3'b000, 32'd0, s, r);
        chk("lw44_stall", 32'(s), 32'd0);
        chk("lw44_data", r, 32'h8765_4321);
        do_access(32'h40, 4'b1000, 3'b000, 32'd0, s, r);
        chk("lb40", r, 32'hFFFF_FFF0);
        do_access(32'h40, 4'b1100, 3'b000, 32'd0, s, r);
        chk("lbu40", r, 32'h0000_00F0);
        do_access(32'h40, 4'b1001, 3'b000, 32'd0, s, r);
        chk("lh40", r, 32'hFFFF_80F0);
        do_access(32'h40, 4'b1101, 3'b000, 32'd0, s, r);
        chk("lhu40", r, 32'h0000_80F0);

        // Store hit dirties the line
        do_access(32'h41, 4'b0000, 3'b100, 32'h0000_00AA, s, r);
        chk("sb41_stall", 32'(s), 32'd0);
        do_access(32'h40, 4'b1010, 3'b000, 32'd0, s, r);
        chk("lw40_after_sb", r, 32'h0000_AAF0);

        // Dirty victim: write-back then fetch
        do_access(32'hC0, 4'b1010, 3'b000, 32'd0, s, r);
        chk("dirty_miss_stall", 32'(s), 32'd11);
        chk("mm_holds_victim", mm_read(4), {32'h0BAD_F00D, 32'h1357_9BDF, 32'h8765_4321, 32'h0000_AAF0});

        // Load and store together on a hit: store wins, no wait
        do_access(32'hC0, 4'b1010, 3'b110, 32'h1234_5678, s, r);
        chk("combo_stall", 32'(s), 32'd0);
        do_access(32'hC0, 4'b1010, 3'b000, 32'd0, s, r);
        chk("combo_data", r, 32'h1234_5678);

        // Randomized traffic with varying memory latency
        for (int t = 0; t < 300; t++) begin
            lat = int'($urandom_range(1, 4));
            a   = $urandom_range(0, 32'h1FFF);
            f3  = 3'($urandom_range(0, 7));
            sz  = 2'($urandom_range(0, 2));
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      do_access(a, {1'b1, f3}, 3'b000, $urandom, s, r);
            else if (sel < 9) do_access(a, 4'b0000, {1'b1, sz}, $urandom, s, r);
            else              do_access(a, {1'b1, f3}, {1'b1, sz}, $urandom, s, r);
        end

        // Reset in the middle of a fetch
        lat = 3;
        bus.ADDRESS = 32'h1040; bus.MEM_READ = 4'b1010; bus.MEM_WRITE = 3'b000;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge CLK);
            if (bus.MAIN_MEM_READ) found = 1'b1;
        end
        chk("fetch_seen", found, 1'b1);
        RST = 1'b1;
        bus.MEM_READ = 4'd0;
        @(posedge CLK);
        @(negedge CLK);
        chk("midrst_busywait", bus.BUSYWAIT, 1'b0);
        chk("midrst_mm_read", bus.MAIN_MEM_READ, 1'b0);
        chk("midrst_mm_write", bus.MAIN_MEM_WRITE, 1'b0);
        RST = 1'b0;
        @(posedge CLK); #1;
        for (int i = 0; i < 8; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
        for (int i = 0; i < NBLK; i++) golden[i] = mm_read(i);
        do_access(32'h40, 4'b1010, 3'b000, 32'd0, s, r);
        chk("post_rst_miss_stall", 32'(s), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
